// File: rtl/axis_2to1_arbiter.sv
// Round-robin burst arbiter for a 2-to-1 AXI-Stream mux: drives CONF and gates the mux output.
// Optional statistics counters are enabled with `define AXIS_ARB_STATS_EN.
module axis_2to1_arbiter #(
  parameter int BURST_LEN = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        sA_tvalid,
  input  logic        sB_tvalid,
  output logic        CONF,
  input  logic        mux_tvalid,
  output logic        mux_tready,
  input  logic [31:0] mux_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        grant_active
`ifdef AXIS_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_a_beats,
  output logic [31:0] stat_b_beats,
  output logic [15:0] stat_switches
`endif
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last_grant, last_nxt;  // 1 = B was served last
  logic       conf_nxt;
  logic       beat;
  logic       own_vld, oth_vld;

  assign grant_active = (state != IDLE);
  assign m_tvalid     = mux_tvalid & grant_active;
  assign mux_tready   = m_tready & grant_active;
  assign m_tdata      = mux_tdata;
  assign beat         = mux_tvalid & m_tready & grant_active;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_grant;
    own_vld   = 1'b0;
    oth_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (sA_tvalid && sB_tvalid)
          state_nxt = last_grant ? GNT_A : GNT_B;
        else if (sA_tvalid)
          state_nxt = GNT_A;
        else if (sB_tvalid)
          state_nxt = GNT_B;
      end
      GNT_A, GNT_B: begin
        own_vld = (state == GNT_A) ? sA_tvalid : sB_tvalid;
        oth_vld = (state == GNT_A) ? sB_tvalid : sA_tvalid;
        // A source with tvalid low is idle, so its tenure ends immediately.
        if ((beat && (cnt == LAST_CNT)) || !own_vld) begin
          cnt_nxt = 8'd0;
          if (oth_vld) begin
            state_nxt = (state == GNT_A) ? GNT_B : GNT_A;
            last_nxt  = (state == GNT_B);
          end else if (!own_vld) begin
            state_nxt = IDLE;
            last_nxt  = (state == GNT_B);
          end
        end else if (beat) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CONF tracks the next grant so it switches on the same edge as the state.
  always_comb begin
    case (state_nxt)
      GNT_A:   conf_nxt = 1'b0;
      GNT_B:   conf_nxt = 1'b1;
      default: conf_nxt = CONF;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
      CONF       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_nxt;
      CONF       <= conf_nxt;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic switch_evt;
  assign switch_evt = ((state == GNT_A) && (state_nxt == GNT_B)) ||
                      ((state == GNT_B) && (state_nxt == GNT_A));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stat_a_beats  <= 32'd0;
      stat_b_beats  <= 32'd0;
      stat_switches <= 16'd0;
    end else if (stat_clr) begin
      stat_a_beats  <= 32'd0;
      stat_b_beats  <= 32'd0;
      stat_switches <= 16'd0;
    end else begin
      if (beat && (state == GNT_A)) stat_a_beats <= sat_inc32(stat_a_beats);
      if (beat && (state == GNT_B)) stat_b_beats <= sat_inc32(stat_b_beats);
      if (switch_evt)               stat_switches <= sat_inc16(stat_switches);
    end
  end
`endif

endmodule

// File: tb/tb_axis_2to1_arbiter.sv
// Directed bench for axis_2to1_arbiter (BURST_LEN = 16): vector table plus multi-cycle sequences.
module tb_axis_2to1_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        sA_tvalid = 1'b0;
  logic        sB_tvalid = 1'b0;
  logic        mux_tvalid = 1'b0;
  logic        m_tready = 1'b0;
  logic [31:0] mux_tdata = 32'd0;
  logic        CONF, mux_tready, m_tvalid, grant_active;
  logic [31:0] m_tdata;
`ifdef AXIS_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_a_beats, stat_b_beats;
  logic [15:0] stat_switches;
`endif

  int total = 0;
  int bad = 0;

  always #5 ACLK = ~ACLK;

  axis_2to1_arbiter #(.BURST_LEN(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .sA_tvalid(sA_tvalid), .sB_tvalid(sB_tvalid), .CONF(CONF),
    .mux_tvalid(mux_tvalid), .mux_tready(mux_tready), .mux_tdata(mux_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .grant_active(grant_active)
`ifdef AXIS_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_a_beats(stat_a_beats),
    .stat_b_beats(stat_b_beats), .stat_switches(stat_switches)
`endif
  );

  // Inputs {a, b, mux_tvalid, m_tready}, expected {CONF, grant_active, m_tvalid, mux_tready}
  typedef struct packed {
    logic a, b, mv, mr;
    logic conf, ga, mtv, mxr;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic mv, input logic mr);
    sA_tvalid  = a;
    sB_tvalid  = b;
    mux_tvalid = mv;
    m_tready   = mr;
    mux_tdata  = $urandom;
  endtask

  // One cycle: apply inputs, check mid-cycle, advance past the next rising edge.
  task automatic cyc(input logic a, input logic b, input logic mv, input logic mr,
                     input logic ec, input logic eg, input string nm);
    drive(a, b, mv, mr);
    #3;
    chk({nm, "_conf"}, 32'(CONF), 32'(ec));
    chk({nm, "_grant"}, 32'(grant_active), 32'(eg));
    chk({nm, "_m_tvalid"}, 32'(m_tvalid), 32'(mv & eg));
    chk({nm, "_mux_tready"}, 32'(mux_tready), 32'(mr & eg));
    chk({nm, "_tdata"}, m_tdata, mux_tdata);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    tbl[0]  = 8'b0001_0000;  // idle, nothing requested
    tbl[1]  = 8'b1011_0000;  // A requests; grant not yet taken
    tbl[2]  = 8'b1011_0111;  // GNT_A beat 1
    tbl[3]  = 8'b1011_0111;
    tbl[4]  = 8'b1011_0111;
    tbl[5]  = 8'b1011_0111;
    tbl[6]  = 8'b1011_0111;  // beat 5
    tbl[7]  = 8'b0001_0101;  // A drops; still in GNT_A this cycle
    tbl[8]  = 8'b0001_0000;  // IDLE
    tbl[9]  = 8'b0111_0000;  // B requests
    tbl[10] = 8'b0111_1111;  // GNT_B
    tbl[11] = 8'b0001_1101;
    tbl[12] = 8'b0001_1000;  // IDLE keeps CONF = 1
    tbl[13] = 8'b1111_1000;  // tie, last = B
    tbl[14] = 8'b1111_0111;  // A wins
    tbl[15] = 8'b1110_0110;  // backpressure
    tbl[16] = 8'b0001_0101;  // both drop -> IDLE, last = A
    tbl[17] = 8'b1111_0000;  // tie, last = A
    tbl[18] = 8'b1111_1111;  // B wins
    tbl[19] = 8'b0001_1101;
    tbl[20] = 8'b0001_1000;
    tbl[21] = 8'b1011_1000;
    tbl[22] = 8'b1011_0111;  // GNT_A
    tbl[23] = 8'b0101_0101;  // A drops while B waits
    tbl[24] = 8'b0111_1111;  // straight to GNT_B, no bubble
    tbl[25] = 8'b0001_1101;
    tbl[26] = 8'b0001_1000;

    // Reset holds the gating shut even with everything asserted
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1 ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_conf", 32'(CONF), 32'd0);
    chk("rst_grant", 32'(grant_active), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mux_tready", 32'(mux_tready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ARESET = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].mv, tbl[i].mr);
      #3;
      chk($sformatf("vec%0d_conf", i), 32'(CONF), 32'(tbl[i].conf));
      chk($sformatf("vec%0d_grant", i), 32'(grant_active), 32'(tbl[i].ga));
      chk($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].mtv));
      chk($sformatf("vec%0d_mux_tready", i), 32'(mux_tready), 32'(tbl[i].mxr));
      chk($sformatf("vec%0d_tdata", i), m_tdata, mux_tdata);
      @(posedge ACLK);
      #1;
    end

    // Contention: 16 A, 16 B, 16 A, 16 B; A withdraws during the last beat
`ifdef AXIS_ARB_STATS_EN
    stat_clr = 1'b1;
`endif
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "cont_idle");
`ifdef AXIS_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int k = 1; k <= 64; k++)
      cyc(k != 64, 1'b1, 1'b1, 1'b1, 1'(((k - 1) / 16) % 2), 1'b1, $sformatf("cont%0d", k));
`ifdef AXIS_ARB_STATS_EN
    chk("stat_a_beats", stat_a_beats, 32'd32);
    chk("stat_b_beats", stat_b_beats, 32'd32);
    chk("stat_switches", 32'(stat_switches), 32'd3);
    stat_clr = 1'b1;
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "cont_tail");
`ifdef AXIS_ARB_STATS_EN
    stat_clr = 1'b0;
    chk("stat_a_clr", stat_a_beats, 32'd0);
    chk("stat_b_clr", stat_b_beats, 32'd0);
    chk("stat_sw_clr", 32'(stat_switches), 32'd0);
`endif

    // B alone for 40 beats: grant never lapses across burst-length boundaries
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "bonly_idle");
    for (int k = 1; k <= 40; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, $sformatf("bonly%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bonly_tail");

    // Stall at cnt = 15 while B waits: switch only after the 16th beat completes
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "stall_idle");
    for (int k = 1; k <= 15; k++)
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, $sformatf("stall_beat%0d", k));
    for (int k = 1; k <= 10; k++)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("stall_wait%0d", k));
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "stall_beat16");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "stall_switch_b");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "stall_tail");

    // Leave last_grant = A, then reset mid-burst in GNT_B with cnt = 7
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "pre_idle");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "pre_a");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "pre_a_drop");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "pre_b_idle");
    for (int k = 1; k <= 7; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, $sformatf("pre_b%0d", k));
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1 ARESET = 1'b1;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_mux_tready", 32'(mux_tready), 32'd0);
    chk("midrst_conf", 32'(CONF), 32'd0);
    chk("midrst_grant", 32'(grant_active), 32'd0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst_idle");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "post_rst_a_first");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "post_rst_a_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
